// File: rtl/bird_physics.sv
// bird_physics: vertical position/velocity of the bird, updated once per frame
// from gravity and player flaps, plus the IDLE/FLYING/DEAD game-state machine.
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset
//   frame_tick  single-cycle pulse, once per frame
//   flap        raw button level, asynchronous to clk
//   collision   bird overlaps a pipe (level)
//   restart     single-cycle pulse, DEAD -> IDLE
//   bird_reg    bird top edge in pixels, zero-extended to 32 bits
//   alive       high in IDLE and FLYING
//   ground_hit  high in DEAD when the floor caused the death
//
// Optional feature: define BIRD_IDLE_BOB_EN to make the bird bob up and down
// by a small triangle offset while waiting in IDLE.
module bird_physics #(
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned BIRD_HEIGHT   = 35,
    parameter int unsigned START_Y       = 200,
    parameter int unsigned FRAC_BITS     = 4,
    parameter int unsigned GRAVITY       = 6,
    parameter int unsigned FLAP_VELOCITY = 64,
    parameter int unsigned MAX_FALL_VEL  = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        flap,
    input  logic        collision,
    input  logic        restart,
    output logic [31:0] bird_reg,
    output logic        alive,
    output logic        ground_hit
);

    localparam int unsigned INT_W = 9;
    localparam int unsigned POS_W = INT_W + FRAC_BITS;
    localparam int unsigned VEL_W = 16;

    localparam logic [POS_W-1:0] START_POS = POS_W'(START_Y << FRAC_BITS);
    localparam logic [POS_W-1:0] FLOOR_POS =
        POS_W'((SCREEN_HEIGHT - BIRD_HEIGHT) << FRAC_BITS);

    localparam logic signed [VEL_W-1:0] GRAV_V = VEL_W'(GRAVITY);
    localparam logic signed [VEL_W-1:0] MAX_V  = VEL_W'(MAX_FALL_VEL);
    localparam logic signed [VEL_W-1:0] FLAP_V = VEL_W'(0) - VEL_W'(FLAP_VELOCITY);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLYING = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [POS_W-1:0]         pos_q, pos_d;
    logic signed [VEL_W-1:0]  vel_q, vel_d;
    logic                     pend_q, pend_d;
    logic                     gh_q, gh_d;
    logic                     flap_meta_q, flap_sync_q, flap_prev_q;
    logic [31:0]              bird_reg_q;
    logic                     alive_q;

    logic                     flap_edge;
    logic                     flap_now;
    logic signed [VEL_W-1:0]  vel_fall;
    logic signed [VEL_W-1:0]  vel_new;
    logic signed [VEL_W-1:0]  pos_new;

`ifdef BIRD_IDLE_BOB_EN
    logic [3:0] bob_cnt_q, bob_cnt_d;

    // Top edge for a bob phase: triangle 0,1,2,3,4,3,2,1 px above START_Y.
    function automatic logic [POS_W-1:0] bob_pos(input logic [2:0] phase);
        logic [2:0] off;
        off = (phase <= 3'd4) ? phase : 3'(4'd8 - {1'b0, phase});
        return POS_W'((START_Y + 32'(off)) << FRAC_BITS);
    endfunction
`endif

    // Next-state logic: physics, game state and flap bookkeeping.
    always_comb begin
        flap_edge = flap_sync_q & ~flap_prev_q;
        flap_now  = pend_q | flap_edge;

        vel_fall = vel_q + GRAV_V;
        if (vel_fall > MAX_V) begin
            vel_fall = MAX_V;
        end
        vel_new = flap_now ? FLAP_V : vel_fall;
        // Signed 16-bit sum so an upward step past the ceiling goes negative
        // instead of wrapping.
        pos_new = $signed(VEL_W'(pos_q)) + vel_new;

        state_d = state_q;
        pos_d   = pos_q;
        vel_d   = vel_q;
        pend_d  = pend_q;
        gh_d    = gh_q;
`ifdef BIRD_IDLE_BOB_EN
        bob_cnt_d = bob_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                vel_d = '0;
`ifdef BIRD_IDLE_BOB_EN
                if (frame_tick) begin
                    bob_cnt_d = bob_cnt_q + 4'd1;
                end
                pos_d = bob_pos(bob_cnt_d[3:1]);
`else
                pos_d = START_POS;
`endif
                // The pending flap survives into FLYING and is applied on
                // the first tick there.
                if (flap_edge) begin
                    state_d = ST_FLYING;
                    pend_d  = 1'b1;
                end
            end

            ST_FLYING: begin
                if (collision) begin
                    // Collision beats a simultaneous tick; position freezes.
                    state_d = ST_DEAD;
                    gh_d    = 1'b0;
                    pend_d  = 1'b0;
                end else if (frame_tick) begin
                    pend_d = 1'b0;
                    if (pos_new < 0) begin
                        pos_d = '0;
                        vel_d = '0;
                    end else if (pos_new >= $signed(VEL_W'(FLOOR_POS))) begin
                        pos_d   = FLOOR_POS;
                        vel_d   = '0;
                        state_d = ST_DEAD;
                        gh_d    = 1'b1;
                    end else begin
                        pos_d = POS_W'(pos_new);
                        vel_d = vel_new;
                    end
                end else begin
                    pend_d = flap_now;
                end
            end

            default: begin
                pend_d = 1'b0;
                if (restart) begin
                    state_d = ST_IDLE;
                    pos_d   = START_POS;
                    vel_d   = '0;
                    gh_d    = 1'b0;
`ifdef BIRD_IDLE_BOB_EN
                    bob_cnt_d = '0;
`endif
                end
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pos_q       <= START_POS;
            vel_q       <= '0;
            pend_q      <= 1'b0;
            gh_q        <= 1'b0;
            flap_meta_q <= 1'b0;
            flap_sync_q <= 1'b0;
            flap_prev_q <= 1'b0;
            bird_reg_q  <= 32'(START_POS[POS_W-1:FRAC_BITS]);
            alive_q     <= 1'b1;
`ifdef BIRD_IDLE_BOB_EN
            bob_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            vel_q       <= vel_d;
            pend_q      <= pend_d;
            gh_q        <= gh_d;
            flap_meta_q <= flap;
            flap_sync_q <= flap_meta_q;
            flap_prev_q <= flap_sync_q;
            bird_reg_q  <= 32'(pos_d[POS_W-1:FRAC_BITS]);
            alive_q     <= (state_d != ST_DEAD);
`ifdef BIRD_IDLE_BOB_EN
            bob_cnt_q   <= bob_cnt_d;
`endif
        end
    end

    assign bird_reg   = bird_reg_q;
    assign alive      = alive_q;
    assign ground_hit = gh_q;

endmodule

// File: tb/tb_bird_physics.sv
// Testbench for bird_physics: directed game scenarios plus randomized play,
// compared every cycle against a frame-level behavioural model.
module tb_bird_physics;

    localparam int M_IDLE = 0;
    localparam int M_FLY  = 1;
    localparam int M_DEAD = 2;
    localparam int START_FP = 200 * 16;
    localparam int FLOOR_FP = 445 * 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        flap = 1'b0;
    logic        collision = 1'b0;
    logic        restart = 1'b0;
    logic [31:0] bird_reg;
    logic        alive;
    logic        ground_hit;

    int errors = 0;
    int checks = 0;

    // Reference model state (position/velocity in 1/16 px).
    int m_mode, m_pos, m_vel, m_gh, m_pend, m_cnt;
    int m_s1, m_s2, m_s3;

    bird_physics dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .flap       (flap),
        .collision  (collision),
        .restart    (restart),
        .bird_reg   (bird_reg),
        .alive      (alive),
        .ground_hit (ground_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int bob_off(input int cnt);
        int ph;
        ph = cnt / 2;
        return (ph <= 4) ? ph : 8 - ph;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_pos = START_FP; m_vel = 0; m_gh = 0; m_pend = 0; m_cnt = 0;
        m_s1 = 0; m_s2 = 0; m_s3 = 0;
    endtask

    // One clock edge of the game rules, given the inputs sampled at that edge.
    task automatic model_step(input int tick, input int fl, input int col, input int rs);
        int edge_seen, fnow, v, p;
        edge_seen = (m_s2 != 0 && m_s3 == 0) ? 1 : 0;
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = fl;
        if (m_mode == M_IDLE) begin
`ifdef BIRD_IDLE_BOB_EN
            if (tick != 0) m_cnt = (m_cnt + 1) % 16;
            m_pos = (200 + bob_off(m_cnt)) * 16;
`endif
            if (edge_seen != 0) begin
                m_mode = M_FLY;
                m_pend = 1;
            end
        end else if (m_mode == M_FLY) begin
            fnow = (m_pend != 0 || edge_seen != 0) ? 1 : 0;
            if (col != 0) begin
                m_mode = M_DEAD; m_gh = 0; m_pend = 0;
            end else if (tick != 0) begin
                m_pend = 0;
                if (fnow != 0) v = -64;
                else v = (m_vel + 6 > 128) ? 128 : m_vel + 6;
                p = m_pos + v;
                if (p < 0) begin
                    m_pos = 0; m_vel = 0;
                end else if (p >= FLOOR_FP) begin
                    m_pos = FLOOR_FP; m_vel = 0; m_mode = M_DEAD; m_gh = 1;
                end else begin
                    m_pos = p; m_vel = v;
                end
            end else begin
                m_pend = fnow;
            end
        end else begin
            m_pend = 0;
            if (rs != 0) begin
                m_mode = M_IDLE; m_pos = START_FP; m_vel = 0; m_gh = 0; m_cnt = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare after it.
    task automatic step(input int tick, input int fl, input int col, input int rs);
        @(negedge clk);
        frame_tick = (tick != 0);
        flap       = (fl != 0);
        collision  = (col != 0);
        restart    = (rs != 0);
        @(posedge clk);
        model_step(tick, fl, col, rs);
        #1;
        check("bird_reg", bird_reg, 32'(m_pos / 16));
        check("alive", 32'(alive), (m_mode == M_DEAD) ? 0 : 1);
        check("ground_hit", 32'(ground_hit), 32'(m_gh));
    endtask

    // Reset asserted between clock edges; values must appear before the next edge.
    task automatic do_reset();
        @(negedge clk);
        frame_tick = 1'b0; flap = 1'b0; collision = 1'b0; restart = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_bird_reg", bird_reg, 200);
        check("rst_alive", 32'(alive), 1);
        check("rst_ground_hit", 32'(ground_hit), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic flap_tick();
        step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0);
    endtask

    task automatic grav_tick();
        step(0, 0, 0, 0); step(1, 0, 0, 0);
    endtask

    initial begin
        int n;
        int fl_lvl;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset and IDLE ticks.
        do_reset();
        repeat (4) grav_tick();
`ifndef BIRD_IDLE_BOB_EN
        check("idle_hold", bird_reg, 200);
`endif

        // First flap then one gravity tick.
        do_reset();
        flap_tick();
        check("flap_tick1", bird_reg, 196);
        grav_tick();
        check("flap_tick2", bird_reg, 192);

        // Free fall to the floor.
        n = 0;
        while (m_mode != M_DEAD && n < 100) begin
            grav_tick();
            n++;
        end
        check("fall_dead_in_budget", 32'(n < 100), 1);
        check("floor_bird_reg", bird_reg, 445);
        check("floor_alive", 32'(alive), 0);
        check("floor_ground_hit", 32'(ground_hit), 1);
        repeat (3) grav_tick();
        check("floor_hold", bird_reg, 445);
        step(0, 0, 0, 1);
        check("restart_bird_reg", bird_reg, 200);

        // Flap every tick up to and against the ceiling.
        repeat (55) flap_tick();
        check("ceiling_bird_reg", bird_reg, 0);
        check("ceiling_alive", 32'(alive), 1);

        // Collision together with a tick at bird_reg 150.
        do_reset();
        repeat (10) flap_tick();
        repeat (3) grav_tick();
        check("pre_coll_bird_reg", bird_reg, 150);
        step(1, 0, 1, 0);
        check("coll_bird_reg", bird_reg, 150);
        check("coll_alive", 32'(alive), 0);
        check("coll_ground_hit", 32'(ground_hit), 0);
        flap_tick();
        grav_tick();
        check("dead_flap_ignored", bird_reg, 150);
        step(0, 0, 0, 1);
        check("coll_restart", bird_reg, 200);
        check("coll_restart_alive", 32'(alive), 1);

        // Flap edge on the tick cycle, then a long held flap.
        do_reset();
        flap_tick();
        grav_tick();
        grav_tick();
        step(0, 1, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0);
        for (int i = 0; i < 24; i++) step(((i % 4) == 3) ? 1 : 0, 1, 0, 0);
        repeat (4) grav_tick();

        // Reset mid-flight.
        flap_tick();
        do_reset();

        // Randomized play.
        fl_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0) fl_lvl = 1 - fl_lvl;
            step(($urandom_range(3) == 0) ? 1 : 0, fl_lvl,
                 ($urandom_range(60) == 0) ? 1 : 0,
                 ($urandom_range(10) == 0) ? 1 : 0);
            if ((i % 1000) == 999) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bird_physics.md
Name: bird_physics

Overview:
- Upstream neighbour of the bird display stage. Owns the bird's vertical position and velocity, updated once per video frame from gravity and player flaps.
- Publishes the bird's top edge as the 32-bit bird_reg word that the display stage consumes.
- Runs a small game-state machine: IDLE, FLYING, DEAD.

Parameters:
- SCREEN_HEIGHT, 480, visible lines.
- BIRD_HEIGHT, 35, sprite height in pixels.
- START_Y, 200, top edge in IDLE and after reset.
- FRAC_BITS, 4, fractional bits of the fixed-point position and velocity.
- GRAVITY, 6, downward velocity increment per frame (Q.FRAC_BITS; 0.375 px/frame²).
- FLAP_VELOCITY, 64, magnitude of the upward velocity set by a flap (4 px/frame).
- MAX_FALL_VEL, 128, downward velocity cap (8 px/frame).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- frame_tick  in  1  single-cycle pulse, once per frame (start of vertical blank).
- flap  in  1  raw button level, asynchronous to clk.
- collision  in  1  level from pipe logic; bird overlaps a pipe.
- restart  in  1  single-cycle pulse; DEAD -> IDLE.
- bird_reg  out  32  bird top edge in pixels, zero-extended: bits[8:0] = integer position, bits[31:9] = 0.
- alive  out  1  high in IDLE and FLYING.
- ground_hit  out  1  high in DEAD when death was caused by reaching the floor.

Behaviour:
- Reset (async, active-high):
  - state = IDLE; pos_q = START_Y << FRAC_BITS; vel = 0; flap_pending = 0.
  - Outputs: bird_reg = 200, alive = 1, ground_hit = 0.
- Flap input:
  - Two-flop synchroniser, then rising-edge detect.
  - An edge sets flap_pending. flap_pending clears on the cycle that consumes it at a frame_tick.
  - An edge in the same cycle as frame_tick is consumed by that tick.
- Arithmetic:
  - pos_q is unsigned, 9+FRAC_BITS bits. vel is signed, 16 bits, positive = downward.
  - The next position is computed in signed 16 bits before clamping, so there is no wrap-around.
- Update latency: all state and outputs are registered. An update caused by frame_tick at cycle N is visible at cycle N+1. Between ticks, outputs hold.
- IDLE:
  - Position held at START_Y, vel = 0.
  - A flap edge moves the state to FLYING; flap_pending stays set, so the first FLYING tick performs the flap.
- FLYING, on each frame_tick:
  - If flap_pending: vel_n = -FLAP_VELOCITY. Otherwise: vel_n = min(vel + GRAVITY, MAX_FALL_VEL).
  - pos_n = pos_q + vel_n.
  - Ceiling: if pos_n < 0, then pos_q = 0 and vel = 0.
  - Floor: if pos_n >= (SCREEN_HEIGHT - BIRD_HEIGHT) << FRAC_BITS, then pos_q = 445 << FRAC_BITS, vel = 0, state = DEAD, ground_hit = 1.
- collision in FLYING:
  - Sampled every cycle, not only on ticks. When high: state = DEAD, ground_hit = 0, position frozen.
  - If collision and a frame_tick occur together: the tick is ignored and collision wins.
- DEAD:
  - Position and vel frozen; alive = 0; flap edges ignored and flap_pending cleared.
  - restart moves the state to IDLE, reloads START_Y, clears vel and ground_hit.
- restart outside DEAD is ignored. A flap edge in IDLE with restart in the same cycle: restart has no effect and the flap is honoured.
- Reset asserted mid-flight forces the reset values immediately, without waiting for clk.

Optional Feature:
- Macro: BIRD_IDLE_BOB_EN.
- Defined:
  - In IDLE, a 4-bit frame counter advances on each frame_tick.
  - bird_reg = START_Y + triangle offset (0,1,2,3,4,3,2,1 px, one step per 2 frames, 16-frame period).
  - The IDLE -> FLYING transition starts physics from the currently displayed bobbed position. The counter clears on entering IDLE.
- Undefined: no counter is synthesised; the IDLE position is constant START_Y.

Test Plan:
- Reset (async, mid-cycle) -> bird_reg=200, alive=1, ground_hit=0 before the next clk edge; no frame_tick activity changes the IDLE position.
- Flap pulse, then 2 frame_ticks -> after tick 1, vel=-64 and bird_reg=196; after tick 2, vel=-58 and bird_reg=192 (pos_q 3078).
- Free fall from 200 with no flaps -> velocity saturates at 128 by tick 22; bird_reg reaches exactly 445, then state DEAD, alive=0, ground_hit=1, bird_reg holds 445 on later ticks.
- Flap on every tick from 200 -> bird_reg decreases by 4 per tick to 0 and clamps at 0 (never wraps to 511), alive stays 1.
- collision asserted mid-flight at bird_reg=150, in the same cycle as frame_tick -> DEAD, ground_hit=0, bird_reg stays 150; a flap is then ignored; restart -> IDLE, bird_reg=200.
- Flap edge coincident with frame_tick in FLYING -> the flap is applied on that tick (vel=-64); a flap held high for many cycles -> only one flap registered.
